bayer_mosaic: RTL

- Re-mosaics a full-RGB pixel stream back into a single-channel 8-bit Bayer raw stream. It is the inverse of the CFA demosaic stage.
- Sits after any RGB-domain processing, or after a synthetic RGB source. It feeds a raw-domain consumer such as the demosaic stage, a raw capture path, or a sensor-model loopback for ISP verification.
- Tracks pixel position per frame, selects one colour channel per site according to the CFA pattern, and flags line/frame geometry errors.

---
 rtl/bayer_mosaic.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bayer_mosaic.sv
// Re-mosaics an RGB pixel stream into an 8-bit Bayer raw stream, with line/frame geometry checks.
// Optional colour-bar test pattern generator enabled by defining BAYER_TESTPAT_EN.
module bayer_mosaic #(
    parameter int unsigned source_h = 1024,
    parameter int unsigned source_v = 1024,
    parameter int unsigned raw_type = 0
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef BAYER_TESTPAT_EN
    input  logic       test_en,
`endif
    input  logic       in_vsync,
    input  logic       in_hsync,
    input  logic       in_den,
    input  logic [7:0] in_data_R,
    input  logic [7:0] in_data_G,
    input  logic [7:0] in_data_B,
    output logic       out_vsync,
    output logic       out_hsync,
    output logic       out_den,
    output logic [7:0] out_raw,
    output logic       line_err,
    output logic       frame_err,
    output logic       frame_done
);

    localparam logic [11:0] CntMax = 12'hFFF;
    localparam logic [11:0] SrcH   = 12'(source_h);
    localparam logic [11:0] SrcV   = 12'(source_v);
    // Every pattern is BGGR with the row and/or column parity flipped.
    localparam logic [1:0]  SiteFlip = {(raw_type == 1) || (raw_type == 3),
                                        (raw_type == 1) || (raw_type == 2)};

    logic [11:0] col_q, col_d, row_q, row_d, row_inc, row_final;
    logic        vsync_prev_q, hsync_prev_q;
    logic        active_q, active_d;
    logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic        vs_rise, vs_fall, line_end;
    logic [1:0]  site;
    logic [7:0]  src_r, src_g, src_b, pix;

    logic        vs_s1, hs_s1, den_s1, done_s1;
    logic [7:0]  raw_s1;

    always_comb begin
        vs_rise   = in_vsync && !vsync_prev_q;
        vs_fall   = !in_vsync && vsync_prev_q && active_q;
        line_end  = !in_hsync && hsync_prev_q && active_q;
        row_inc   = (row_q == CntMax) ? row_q : row_q + 12'd1;
        row_final = line_end ? row_inc : row_q;

        col_d = col_q;
        if (!in_hsync) begin
            col_d = '0;
        end else if (in_den && col_q != CntMax) begin
            col_d = col_q + 12'd1;
        end

        row_d = row_q;
        if (!in_vsync) begin
            row_d = '0;
        end else if (line_end) begin
            row_d = row_inc;
        end

        active_d = active_q;
        if (vs_rise) begin
            active_d = 1'b1;
        end else if (!in_vsync) begin
            active_d = 1'b0;
        end

        line_err_d = line_err_q;
        if (vs_rise) begin
            line_err_d = 1'b0;
        end else if (line_end && col_q != SrcH) begin
            line_err_d = 1'b1;
        end

        frame_err_d = frame_err_q;
        if (vs_rise) begin
            frame_err_d = 1'b0;
        end else if (vs_fall) begin
            frame_err_d = (row_final != SrcV);
        end
    end

`ifdef BAYER_TESTPAT_EN
    localparam int unsigned BarW    = (source_h / 8 == 0) ? 1 : source_h / 8;
    localparam logic [11:0] BarLast = 12'(BarW - 1);

    logic        tp_q, tp_on;
    logic [2:0]  bar_q, bar_d;
    logic [11:0] bar_px_q, bar_px_d;

    always_comb begin
        tp_on    = vs_rise ? test_en : tp_q;
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        if (!in_hsync) begin
            bar_d    = '0;
            bar_px_d = '0;
        end else if (in_den) begin
            if (bar_px_q == BarLast && bar_q != 3'd7) begin
                bar_d    = bar_q + 3'd1;
                bar_px_d = '0;
            end else if (bar_px_q != CntMax) begin
                bar_px_d = bar_px_q + 12'd1;
            end
        end
        // Bar index bits map directly onto the missing primaries of the bar order.
        src_r = tp_on ? {8{~bar_q[1]}} : in_data_R;
        src_g = tp_on ? {8{~bar_q[2]}} : in_data_G;
        src_b = tp_on ? {8{~bar_q[0]}} : in_data_B;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tp_q     <= 1'b0;
            bar_q    <= '0;
            bar_px_q <= '0;
        end else begin
            if (vs_rise) tp_q <= test_en;
            bar_q    <= bar_d;
            bar_px_q <= bar_px_d;
        end
    end
`else
    always_comb begin
        src_r = in_data_R;
        src_g = in_data_G;
        src_b = in_data_B;
    end
`endif

    always_comb begin
        site = {row_q[0], col_q[0]} ^ SiteFlip;
        unique case (site)
            2'b00:   pix = src_b;
            2'b11:   pix = src_r;
            default: pix = src_g;
        endcase
    end

    // vsync_prev resets high so a frame already in progress at reset release is not
    // mistaken for a new one; the block waits for the next genuine rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            vsync_prev_q <= 1'b1;
            hsync_prev_q <= 1'b0;
            active_q     <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            vsync_prev_q <= in_vsync;
            hsync_prev_q <= in_hsync;
            active_q     <= active_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s1      <= 1'b0;
            hs_s1      <= 1'b0;
            den_s1     <= 1'b0;
            done_s1    <= 1'b0;
            raw_s1     <= '0;
            out_vsync  <= 1'b0;
            out_hsync  <= 1'b0;
            out_den    <= 1'b0;
            out_raw    <= '0;
            frame_done <= 1'b0;
        end else begin
            vs_s1      <= in_vsync;
            hs_s1      <= in_hsync;
            den_s1     <= in_den;
            done_s1    <= vs_fall;
            raw_s1     <= pix;
            out_vsync  <= vs_s1;
            out_hsync  <= hs_s1;
            out_den    <= den_s1;
            out_raw    <= den_s1 ? raw_s1 : 8'h00;
            frame_done <= done_s1;
        end
    end

    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;

endmodule
